// File: rtl/cksum_pkg.sv
// Shared types, sizes and the ones'-complement fold helper for the checksum unit.
package cksum_pkg;

  localparam int HDR_MAX_LEN = 64;
  localparam int HDR_IDX_W   = 6;
  localparam int BYTE_W      = 8;
  localparam int ADDR_W      = 8;
  localparam int LEN_W       = 8;
  localparam int HALF_W      = 16;
  // Internal pointer is wider than the address so start+len never wraps.
  localparam int PTR_W       = ADDR_W + 2;

  localparam logic [HALF_W-1:0] CKSUM_ZERO_LEN_VAL = 16'hFFFF;

  typedef enum logic [1:0] {
    CKSUM_IDLE = 2'd0,
    CKSUM_SUM  = 2'd1,
    CKSUM_FOLD = 2'd2
  } cksum_state_t;

  // Two-step end-around carry fold; callers zero-extend their accumulator to 64 bits.
  function automatic logic [15:0] fold16(input logic [63:0] acc);
    logic [48:0] s1;
    logic [16:0] s2;
    s1 = {33'b0, acc[15:0]} + {1'b0, acc[63:16]};
    s2 = {1'b0, s1[15:0]} + {16'b0, s1[16]};
    return s2[15:0];
  endfunction

endpackage

// File: rtl/cksum_word_adder.sv
// Combinational sum of up to WORDS_PER_CYCLE big-endian 16-bit header words,
// masking bytes past the remaining length and bytes beyond the header.
module cksum_word_adder
  import cksum_pkg::*;
#(
  parameter int WORDS_PER_CYCLE = 2,
  parameter int ACC_W           = 32
) (
  input  logic [HDR_MAX_LEN-1:0][BYTE_W-1:0] pkt_hdr_i,
  input  logic [PTR_W-1:0]                   ptr,
  input  logic [LEN_W-1:0]                   rem,
  output logic [ACC_W-1:0]                   word_sum
);

  function automatic logic [BYTE_W-1:0] pick_byte(
    input logic [HDR_MAX_LEN-1:0][BYTE_W-1:0] hdr,
    input logic [PTR_W-1:0]                   base,
    input logic [LEN_W-1:0]                   left,
    input int                                 off
  );
    logic [31:0] idx;
    idx = 32'(base) + 32'(off);
    if ((32'(off) < 32'(left)) && (idx < 32'(HDR_MAX_LEN)))
      return hdr[idx[HDR_IDX_W-1:0]];
    return '0;
  endfunction

  always_comb begin
    word_sum = '0;
    for (int k = 0; k < WORDS_PER_CYCLE; k++) begin
      word_sum = word_sum + {{(ACC_W-16){1'b0}},
                             pick_byte(pkt_hdr_i, ptr, rem, 2*k),
                             pick_byte(pkt_hdr_i, ptr, rem, 2*k+1)};
    end
  end

endmodule

// File: rtl/cksum_unit.sv
// RFC 1071 checksum responder: IDLE latches the request, SUM accumulates words,
// FOLD folds carries and issues a one-cycle ready pulse with the complement.
module cksum_unit
  import cksum_pkg::*;
#(
  parameter int WORDS_PER_CYCLE = 2,
  parameter int ACC_W           = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start_i,
  input  logic [HDR_MAX_LEN-1:0][BYTE_W-1:0] pkt_hdr_i,
  input  logic [ADDR_W-1:0]                  field_start_i,
  input  logic [LEN_W-1:0]                   field_len_i,
  output logic [HALF_W-1:0]                  cksum_val_o,
  output logic                               cksum_ready_o,
  output cksum_state_t                       state_dbg
);

  // Handshake: start_i is a one-cycle request honoured only in IDLE; cksum_ready_o
  // is a one-cycle pulse during which cksum_val_o carries the result (no backpressure).

  localparam logic [LEN_W-1:0] STEP = LEN_W'(2 * WORDS_PER_CYCLE);

  cksum_state_t       state_q, state_d;
  logic [PTR_W-1:0]   ptr_q;
  logic [LEN_W-1:0]   rem_q;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   word_sum;
  logic               last_step;

  cksum_word_adder #(
    .WORDS_PER_CYCLE (WORDS_PER_CYCLE),
    .ACC_W           (ACC_W)
  ) u_adder (
    .pkt_hdr_i (pkt_hdr_i),
    .ptr       (ptr_q),
    .rem       (rem_q),
    .word_sum  (word_sum)
  );

  assign last_step = (rem_q <= STEP);
  assign state_dbg = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      CKSUM_IDLE: if (start_i) state_d = (field_len_i != '0) ? CKSUM_SUM : CKSUM_FOLD;
      CKSUM_SUM:  if (last_step) state_d = CKSUM_FOLD;
      CKSUM_FOLD: state_d = CKSUM_IDLE;
      default:    state_d = CKSUM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= CKSUM_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q         <= '0;
      rem_q         <= '0;
      acc_q         <= '0;
      cksum_val_o   <= '0;
      cksum_ready_o <= 1'b0;
    end else begin
      cksum_ready_o <= (state_q == CKSUM_FOLD);
      case (state_q)
        CKSUM_IDLE: begin
          if (start_i) begin
            ptr_q <= {{(PTR_W-ADDR_W){1'b0}}, field_start_i};
            rem_q <= field_len_i;
            acc_q <= '0;
          end
        end
        CKSUM_SUM: begin
          acc_q <= acc_q + word_sum;
          ptr_q <= ptr_q + PTR_W'(STEP);
          rem_q <= last_step ? '0 : (rem_q - STEP);
        end
        CKSUM_FOLD: begin
          cksum_val_o <= ~fold16({{(64-ACC_W){1'b0}}, acc_q});
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cksum_unit.sv
// Scoreboarded bench for cksum_unit: directed RFC 1071 cases plus randomized requests.
module tb_cksum_unit;
  import cksum_pkg::*;

  logic                               clk;
  logic                               rst;
  logic                               start_i;
  logic [HDR_MAX_LEN-1:0][BYTE_W-1:0] hdr;
  logic [ADDR_W-1:0]                  field_start_i;
  logic [LEN_W-1:0]                   field_len_i;
  logic [HALF_W-1:0]                  cksum_val_o;
  logic                               cksum_ready_o;
  cksum_state_t                       state_dbg;

  logic [15:0] exp_q[$];
  int          exp_cyc_q[$];
  int          cyc;
  int          n_checks;
  int          n_pass;
  logic        prev_ready;

  cksum_unit #(.WORDS_PER_CYCLE(2), .ACC_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .pkt_hdr_i     (hdr),
    .field_start_i (field_start_i),
    .field_len_i   (field_len_i),
    .cksum_val_o   (cksum_val_o),
    .cksum_ready_o (cksum_ready_o),
    .state_dbg     (state_dbg)
  );

  // clock / cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference: byte-wise big-endian sum with repeated end-around carry.
  function automatic logic [15:0] ref_cksum(input logic [HDR_MAX_LEN-1:0][BYTE_W-1:0] h,
                                            input int start, input int len);
    longint s;
    longint b;
    logic [15:0] r;
    s = 0;
    for (int i = 0; i < len; i++) begin
      b = (start + i < HDR_MAX_LEN) ? longint'(h[start + i]) : 0;
      s += (i % 2 == 0) ? b * 256 : b;
    end
    while ((s >> 16) != 0) s = (s & 'hFFFF) + (s >> 16);
    r = s[15:0];
    return ~r;
  endfunction

  // driver: called aligned to a negedge; pulses start for one cycle
  task automatic issue(input int start, input int len, input logic [15:0] exp_val);
    int n;
    n = (len + 3) / 4;
    field_start_i = ADDR_W'(start);
    field_len_i   = LEN_W'(len);
    start_i       = 1'b1;
    exp_q.push_back(exp_val);
    exp_cyc_q.push_back(cyc + n + 2);
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic issue_rand(input int start, input int len);
    issue(start, len, ref_cksum(hdr, start, len));
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL timeout: %0d responses outstanding", exp_q.size());
      exp_q.delete();
      exp_cyc_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic load_ipv4();
    logic [7:0] b [20];
    b = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
          8'h00, 8'h00, 8'hc0, 8'ha8, 8'h00, 8'h01, 8'hc0, 8'ha8, 8'h00, 8'hc7};
    hdr = '0;
    for (int i = 0; i < 20; i++) hdr[i] = b[i];
  endtask

  // monitor / scoreboard
  initial prev_ready = 1'b0;
  always @(negedge clk) begin
    if (cksum_ready_o === 1'b1) begin
      check("ready_not_back_to_back", {31'b0, prev_ready}, 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_ready: val %0h with nothing pending (cycle %0d)", cksum_val_o, cyc);
      end else begin
        check("cksum_val", {16'b0, cksum_val_o}, {16'b0, exp_q.pop_front()});
        check("ready_cycle", cyc, exp_cyc_q.pop_front());
      end
    end
    prev_ready = cksum_ready_o;
  end

  initial begin
    int c0;
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b0;
    start_i = 1'b0;
    hdr = '0;
    field_start_i = '0;
    field_len_i = '0;
    repeat (3) @(negedge clk);
    check("reset_val", {16'b0, cksum_val_o}, 32'h0);
    check("reset_ready", {31'b0, cksum_ready_o}, 32'h0);
    check("reset_state", {30'b0, state_dbg}, {30'b0, CKSUM_IDLE});
    rst = 1'b1;
    @(negedge clk);

    // IPv4 header
    load_ipv4();
    issue(0, 20, 16'hB861);
    wait_done();

    // odd length tail
    hdr = '0;
    hdr[0] = 8'h01; hdr[1] = 8'h02; hdr[2] = 8'h03;
    issue(0, 3, 16'hFBFD);
    wait_done();

    // carry fold to 0x0000
    for (int i = 0; i < 4; i++) hdr[i] = 8'hFF;
    issue(0, 4, 16'h0000);
    wait_done();

    // zero length
    issue(5, 0, CKSUM_ZERO_LEN_VAL);
    wait_done();

    // end of header: only last byte counts
    hdr = '0;
    hdr[HDR_MAX_LEN-1] = 8'h5A;
    issue(HDR_MAX_LEN-1, 4, ~16'h5A00);
    wait_done();

    // start during SUM ignored
    load_ipv4();
    issue(0, 20, 16'hB861);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_done();

    // new start accepted in the ready cycle
    c0 = cyc;
    issue(0, 20, 16'hB861);
    while (cyc < c0 + 7) @(negedge clk);
    issue(0, 3, ref_cksum(hdr, 0, 3));
    wait_done();

    // async reset mid-SUM drops the request
    issue(0, 20, 16'hB861);
    @(negedge clk);
    #3;
    rst = 1'b0;
    exp_q.delete();
    exp_cyc_q.delete();
    #1;
    check("async_rst_val", {16'b0, cksum_val_o}, 32'h0);
    check("async_rst_ready", {31'b0, cksum_ready_o}, 32'h0);
    check("async_rst_state", {30'b0, state_dbg}, {30'b0, CKSUM_IDLE});
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    check("post_rst_val_held", {16'b0, cksum_val_o}, 32'h0);
    issue(0, 20, 16'hB861);
    wait_done();

    // randomized requests, including ranges that run off the header
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < HDR_MAX_LEN; i++) hdr[i] = 8'($urandom_range(0, 255));
      issue_rand($urandom_range(0, 70), $urandom_range(0, 40));
      wait_done();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
